// File: rtl/imm_gen_pkg.sv
// Shared opcodes, format codes and stat widths for the buffered immediate generator.
// Pure declarations: no latency, no flow control.
package imm_gen_pkg;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam int STAT_ACC_W = 32;
    localparam int STAT_ILL_W = 16;

endpackage

// File: rtl/imm_decode.sv
// Purpose: maps a raw RV32I/RV64I instruction word to its sign-extended immediate, format and illegal flag.
// Latency: purely combinational. Backpressure: none, no state.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        s;

    assign s = instr[31];

    always_comb begin
        imm32   = '0;
        fmt     = FMT_ILL;
        illegal = 1'b0;
        unique case (instr[6:0])
            OP_OP, OP_OP32: begin
                fmt = FMT_R;
            end
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_MISC_MEM: begin
                fmt   = FMT_I;
                imm32 = {{20{s}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{s}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                fmt     = FMT_ILL;
                illegal = 1'b1;
            end
        endcase
    end

    // Every format keeps its sign in bit 31, so one extension step covers XLEN=32 and 64.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: immediate decoder feeding a DEPTH-entry elastic buffer; IMM_GEN_PIPE_STATS_EN adds push/illegal counters.
// Latency: 1 cycle from accepted word to out_valid, no bypass.
// Backpressure: in_ready = (count < DEPTH) from registered count only; full buffer ignores in_valid.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_GEN_PIPE_STATS_EN
    ,
    output logic [STAT_ACC_W-1:0] stat_accepted,
    output logic [STAT_ILL_W-1:0] stat_illegal
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .imm     (dec.imm),
        .fmt     (dec.fmt),
        .illegal (dec.illegal)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible unless count says the slot is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head        = mem[rd_ptr];
    assign out_imm     = out_valid ? head.imm : '0;
    assign out_fmt     = out_valid ? head.fmt : FMT_R;
    assign out_illegal = out_valid && head.illegal;

`ifdef IMM_GEN_PIPE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_accepted <= '0;
            stat_illegal  <= '0;
        end else if (push) begin
            stat_accepted <= stat_accepted + 1'b1;
            if (dec.illegal && (stat_illegal != '1))
                stat_illegal <= stat_illegal + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed vector table plus backpressure, simultaneous push/pop and mid-run reset sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic        out_illegal32;

`ifdef IMM_GEN_PIPE_STATS_EN
    logic [31:0] stat_accepted, stat_accepted32;
    logic [15:0] stat_illegal, stat_illegal32;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
`ifdef IMM_GEN_PIPE_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_illegal  (stat_illegal)
`endif
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(1)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_instr    (in_instr),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (out_imm32),
        .out_fmt     (out_fmt32),
        .out_illegal (out_illegal32)
`ifdef IMM_GEN_PIPE_STATS_EN
        ,
        .stat_accepted (stat_accepted32),
        .stat_illegal  (stat_illegal32)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h00812083, 64'h0000000000000008, 3'd1, 1'b0}; // lw
        vecs[1]  = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0}; // sw -4
        vecs[2]  = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0}; // beq -8
        vecs[3]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui
        vecs[4]  = '{32'h0010006F, 64'h0000000000000800, 3'd5, 1'b0}; // jal +0x800
        vecs[5]  = '{32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1}; // illegal
        vecs[6]  = '{32'h002081B3, 64'h0000000000000000, 3'd0, 1'b0}; // add
        vecs[7]  = '{32'h00001097, 64'h0000000000001000, 3'd4, 1'b0}; // auipc
        vecs[8]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // addi -1
        vecs[9]  = '{32'h00112423, 64'h0000000000000008, 3'd2, 1'b0}; // sw +8
        vecs[10] = '{32'h0010809B, 64'h0000000000000001, 3'd1, 1'b0}; // addiw 1
        vecs[11] = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0}; // jal -4
        vecs[12] = '{32'h00000000, 64'h0000000000000000, 3'd7, 1'b1}; // opcode 0

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_imm",   out_imm,        64'd0);
        check("rst_out_fmt",   64'(out_fmt),   64'd0);
        check("rst_out_ill",   64'(out_illegal), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_imm", i),   out_imm,        vecs[i].imm);
            check($sformatf("v%0d_fmt", i),   64'(out_fmt),   64'(vecs[i].fmt));
            check($sformatf("v%0d_ill", i),   64'(out_illegal), 64'(vecs[i].ill));
            check($sformatf("v%0d_imm32", i), 64'(out_imm32), {32'd0, vecs[i].imm[31:0]});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
        end
        check("empty_imm_zero", out_imm, 64'd0);
        check("empty_fmt_zero", 64'(out_fmt), 64'd0);
`ifdef IMM_GEN_PIPE_STATS_EN
        check("stat_accepted", 64'(stat_accepted), 64'd13);
        check("stat_illegal",  64'(stat_illegal),  64'd2);
`endif

        // Backpressure: third word must be refused while full.
        in_valid = 1'b1;
        in_instr = 32'h00812083;
        tick();
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        in_instr = 32'hFE112E23;
        tick();
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        in_instr = 32'h0010006F;
        tick();
        in_valid = 1'b0;
        check("bp_ready_full", 64'(in_ready), 64'd0);
        check("bp_head_held",  out_imm, 64'h8);
        out_ready = 1'b1;
        tick();
        check("bp_ready_after_pop", 64'(in_ready), 64'd1);
        check("bp_second_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        check("bp_second_fmt", 64'(out_fmt), 64'd2);
        tick();
        out_ready = 1'b0;
        check("bp_third_dropped", 64'(out_valid), 64'd0);

        // Simultaneous push and pop at count=1.
        in_valid = 1'b1;
        in_instr = 32'hFE000CE3;
        tick();
        in_instr  = 32'h800000B7;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_valid", 64'(out_valid), 64'd1);
        check("pp_ready", 64'(in_ready),  64'd1);
        check("pp_order", out_imm, 64'hFFFFFFFF80000000);
        tick();
        out_ready = 1'b0;
        check("pp_drained", 64'(out_valid), 64'd0);

        // Reset with two entries held.
        in_valid = 1'b1;
        in_instr = 32'h00812083;
        tick();
        tick();
        in_valid = 1'b0;
        check("mr_full", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_in_ready",  64'(in_ready),  64'd1);
        check("mr_out_imm",   out_imm,        64'd0);
`ifdef IMM_GEN_PIPE_STATS_EN
        check("mr_stat_acc", 64'(stat_accepted), 64'd0);
        check("mr_stat_ill", 64'(stat_illegal),  64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
